// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared constants, FSM encoding and hex-to-ASCII helper for the status UART
package uart_pkg;

  localparam int CLK_HZ_DEFAULT = 50_000_000;
  localparam int BAUD_DEFAULT   = 115_200;
  localparam int CLKS_PER_BIT   = CLK_HZ_DEFAULT / BAUD_DEFAULT;
  localparam int MSG_LEN        = 14;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_LOAD,
    TX_SEND,
    TX_NEXT,
    TX_FINISH
  } tx_fsm_t;

  function automatic logic [7:0] hex2ascii(input logic [3:0] v);
    if (v < 4'd10) begin
      return 8'h30 + {4'h0, v};
    end else begin
      return 8'h41 + {4'h0, v} - 8'd10;
    end
  endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// rtl/uart_tx_byte.sv - 8N1 byte serializer owning the baud counter and bit index
module uart_tx_byte
  import uart_pkg::*;
#(
  parameter int BIT_CLKS = CLKS_PER_BIT
) (
  input  logic       clk_50MHz,
  input  logic       reset_n,
  input  logic [7:0] data,
  input  logic       valid,
  output logic       ready,
  output logic       byte_done,
  output logic       tx
);

  localparam int            CW       = $clog2(BIT_CLKS);
  localparam logic [CW-1:0] LAST_CNT = CW'(BIT_CLKS - 1);
  localparam logic [CW-1:0] DONE_CNT = CW'(BIT_CLKS - 3);

  logic [CW-1:0] r_cnt;
  logic [3:0]    r_bit_idx;
  logic [8:0]    r_shift;
  logic          r_active;
  logic          r_tx;
  logic          w_bit_end;
  logic          w_stop_bit;
  logic          w_load;

  assign w_bit_end  = (r_cnt == LAST_CNT);
  assign w_stop_bit = r_active && (r_bit_idx == 4'd9);
  // A new byte may enter on the last cycle of the stop bit, so frames abut with no gap.
  assign ready      = !r_active || (w_stop_bit && w_bit_end);
  assign w_load     = valid && ready;
  // Leads the stop-bit end by two cycles: the caller's NEXT step then lands the next byte on the frame boundary.
  assign byte_done  = w_stop_bit && (r_cnt == DONE_CNT);
  assign tx         = r_tx;

  always_ff @(posedge clk_50MHz) begin
    if (!reset_n) begin
      r_active  <= 1'b0;
      r_tx      <= 1'b1;
      r_cnt     <= '0;
      r_bit_idx <= '0;
      r_shift   <= '1;
    end else if (w_load) begin
      r_active  <= 1'b1;
      r_tx      <= 1'b0;
      r_cnt     <= '0;
      r_bit_idx <= '0;
      r_shift   <= {1'b1, data};
    end else if (r_active) begin
      if (w_bit_end) begin
        r_cnt <= '0;
        if (r_bit_idx == 4'd9) begin
          r_active <= 1'b0;
          r_tx     <= 1'b1;
        end else begin
          r_bit_idx <= r_bit_idx + 4'd1;
          r_tx      <= r_shift[0];
          r_shift   <= {1'b1, r_shift[8:1]};
        end
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/status_uart_tx.sv
// rtl/status_uart_tx.sv - snapshots tetris state/ctrl/score and sends it as a 14-byte ASCII status line
module status_uart_tx
  import uart_pkg::*;
#(
  parameter int CLK_HZ = CLK_HZ_DEFAULT,
  parameter int BAUD   = BAUD_DEFAULT
) (
  input  logic        clk_50MHz,
  input  logic        reset_n,
  input  logic [7:0]  state,
  input  logic [7:0]  ctrl,
  input  logic [15:0] score,
  input  logic        send_req,
  output logic        uart_tx,
  output logic        busy,
  output logic        msg_done
);

  localparam int         BIT_CLKS = CLK_HZ / BAUD;
  localparam logic [3:0] LAST_IDX = 4'(MSG_LEN - 1);

  tx_fsm_t     r_fsm;
  tx_fsm_t     w_fsm_nxt;
  logic [7:0]  r_last_state;
  logic [15:0] r_last_score;
  logic [7:0]  r_snap_state;
  logic [7:0]  r_snap_ctrl;
  logic [15:0] r_snap_score;
  logic [3:0]  r_byte_idx;
  logic [3:0]  w_byte_idx_nxt;
  logic [3:0]  w_tx_idx;
  logic [7:0]  w_tx_data;
  logic        r_pending;
  logic        r_busy;
  logic        r_msg_done;
  logic        w_pending_nxt;
  logic        w_busy_nxt;
  logic        w_msg_done_nxt;
  logic        w_trig;
  logic        w_snap;
  logic        w_valid;
  logic        w_ready;
  logic        w_byte_done;
  logic        w_tx;

  assign w_trig   = send_req | (state != r_last_state) | (score != r_last_score);
  assign uart_tx  = w_tx;
  assign busy     = r_busy;
  assign msg_done = r_msg_done;

  always_ff @(posedge clk_50MHz) begin
    if (!reset_n) begin
      r_fsm        <= TX_IDLE;
      r_byte_idx   <= '0;
      r_pending    <= 1'b0;
      r_busy       <= 1'b0;
      r_msg_done   <= 1'b0;
      r_last_state <= state;
      r_last_score <= score;
      r_snap_state <= '0;
      r_snap_ctrl  <= '0;
      r_snap_score <= '0;
    end else begin
      r_fsm      <= w_fsm_nxt;
      r_byte_idx <= w_byte_idx_nxt;
      r_pending  <= w_pending_nxt;
      r_busy     <= w_busy_nxt;
      r_msg_done <= w_msg_done_nxt;
      if (w_snap) begin
        r_snap_state <= state;
        r_snap_ctrl  <= ctrl;
        r_snap_score <= score;
        r_last_state <= state;
        r_last_score <= score;
      end
    end
  end

  always_comb begin
    w_fsm_nxt      = r_fsm;
    w_byte_idx_nxt = r_byte_idx;
    w_tx_idx       = r_byte_idx;
    w_pending_nxt  = r_pending;
    w_busy_nxt     = r_busy;
    w_msg_done_nxt = 1'b0;
    w_snap         = 1'b0;
    w_valid        = 1'b0;
    case (r_fsm)
      TX_IDLE: begin
        if (w_trig) begin
          w_snap         = 1'b1;
          w_byte_idx_nxt = '0;
          w_busy_nxt     = 1'b1;
          w_fsm_nxt      = TX_LOAD;
        end
      end
      TX_LOAD: begin
        w_valid        = 1'b1;
        w_byte_idx_nxt = '0;
        w_fsm_nxt      = TX_SEND;
      end
      TX_SEND: begin
        w_valid = 1'b1;
        if (w_byte_done) begin
          w_fsm_nxt = TX_NEXT;
        end
      end
      TX_NEXT: begin
        if (r_byte_idx == LAST_IDX) begin
          w_fsm_nxt = TX_FINISH;
        end else begin
          w_byte_idx_nxt = r_byte_idx + 4'd1;
          w_fsm_nxt      = TX_SEND;
        end
      end
      TX_FINISH: begin
        w_msg_done_nxt = 1'b1;
        w_tx_idx       = '0;
        // Byte 0 is the constant 'S', so the follow-on line can start before the new snapshot lands.
        if (r_pending || w_trig) begin
          w_snap         = 1'b1;
          w_valid        = 1'b1;
          w_byte_idx_nxt = '0;
          w_pending_nxt  = 1'b0;
          w_fsm_nxt      = TX_LOAD;
        end else begin
          w_busy_nxt = 1'b0;
          w_fsm_nxt  = TX_IDLE;
        end
      end
      default: begin
        w_fsm_nxt = TX_IDLE;
      end
    endcase
    if ((r_fsm == TX_LOAD || r_fsm == TX_SEND || r_fsm == TX_NEXT) && w_trig) begin
      w_pending_nxt = 1'b1;
    end
  end

  always_comb begin
    case (w_tx_idx)
      4'd0:    w_tx_data = 8'h53;
      4'd1:    w_tx_data = hex2ascii(r_snap_state[7:4]);
      4'd2:    w_tx_data = hex2ascii(r_snap_state[3:0]);
      4'd3:    w_tx_data = 8'h20;
      4'd4:    w_tx_data = 8'h43;
      4'd5:    w_tx_data = hex2ascii(r_snap_ctrl[7:4]);
      4'd6:    w_tx_data = hex2ascii(r_snap_ctrl[3:0]);
      4'd7:    w_tx_data = 8'h20;
      4'd8:    w_tx_data = hex2ascii(r_snap_score[15:12]);
      4'd9:    w_tx_data = hex2ascii(r_snap_score[11:8]);
      4'd10:   w_tx_data = hex2ascii(r_snap_score[7:4]);
      4'd11:   w_tx_data = hex2ascii(r_snap_score[3:0]);
      4'd12:   w_tx_data = 8'h0D;
      default: w_tx_data = 8'h0A;
    endcase
  end

  uart_tx_byte #(
    .BIT_CLKS (BIT_CLKS)
  ) u_tx_byte (
    .clk_50MHz (clk_50MHz),
    .reset_n   (reset_n),
    .data      (w_tx_data),
    .valid     (w_valid),
    .ready     (w_ready),
    .byte_done (w_byte_done),
    .tx        (w_tx)
  );

  logic w_unused;
  assign w_unused = w_ready;

endmodule

// File: tb/tb_status_uart_tx.sv
// tb/tb_status_uart_tx.sv - self-checking bench: UART line decoder plus string-level reference model
module tb_status_uart_tx;

  localparam int CLK_HZ = 1600;
  localparam int BAUD   = 100;
  localparam int CPB    = CLK_HZ / BAUD;
  localparam int FRAME  = 10 * CPB;
  localparam int LINE   = 14 * FRAME;

  logic        clk_50MHz = 1'b0;
  logic        reset_n   = 1'b0;
  logic [7:0]  state     = 8'h00;
  logic [7:0]  ctrl      = 8'h00;
  logic [15:0] score     = 16'h0000;
  logic        send_req  = 1'b0;
  logic        uart_tx;
  logic        busy;
  logic        msg_done;

  status_uart_tx #(.CLK_HZ(CLK_HZ), .BAUD(BAUD)) dut (
    .clk_50MHz (clk_50MHz),
    .reset_n   (reset_n),
    .state     (state),
    .ctrl      (ctrl),
    .score     (score),
    .send_req  (send_req),
    .uart_tx   (uart_tx),
    .busy      (busy),
    .msg_done  (msg_done)
  );

  always #10 clk_50MHz = ~clk_50MHz;

  int cyc = 0;
  always @(posedge clk_50MHz) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;
  bit mon_en  = 1'b0;

  logic [7:0] q_bytes[$];
  int         q_start[$];
  bit         q_stop[$];
  int         q_done[$];

  typedef struct {
    logic [7:0]  s;
    logic [7:0]  c;
    logic [15:0] sc;
    string       exp;
  } vec_t;

  // Line receiver: sample each bit at its middle, record frame start cycle and stop-bit validity.
  initial begin : rx
    logic [7:0] b;
    int         t0;
    forever begin
      @(negedge clk_50MHz);
      if (mon_en && uart_tx === 1'b0) begin
        t0 = cyc;
        repeat (CPB / 2) @(negedge clk_50MHz);
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) @(negedge clk_50MHz);
          b[i] = uart_tx;
        end
        repeat (CPB) @(negedge clk_50MHz);
        q_stop.push_back(uart_tx === 1'b1);
        q_start.push_back(t0);
        q_bytes.push_back(b);
      end
    end
  end

  always @(negedge clk_50MHz) if (mon_en && msg_done === 1'b1) q_done.push_back(cyc);

  function automatic string hex_str(input logic [15:0] v, input int n);
    string hx = "0123456789ABCDEF";
    string r  = "";
    int    d;
    for (int i = n - 1; i >= 0; i--) begin
      d = int'((v >> (4 * i)) & 16'hF);
      r = {r, hx.substr(d, d)};
    end
    return r;
  endfunction

  function automatic string model_line(input logic [7:0] s, input logic [7:0] c, input logic [15:0] sc);
    return {"S", hex_str({8'h00, s}, 2), " C", hex_str({8'h00, c}, 2), " ", hex_str(sc, 4), "\015\012"};
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  task automatic clear_q();
    q_bytes.delete();
    q_start.delete();
    q_stop.delete();
    q_done.delete();
  endtask

  task automatic request(input logic [7:0] s, input logic [7:0] c, input logic [15:0] sc, output int req_edge);
    @(negedge clk_50MHz);
    state    = s;
    ctrl     = c;
    score    = sc;
    send_req = 1'b1;
    req_edge = cyc + 1;
    @(negedge clk_50MHz);
    send_req = 1'b0;
  endtask

  task automatic wait_done(input string name, input int n, input int budget);
    int k = 0;
    while (q_done.size() < n && k < budget) begin
      @(negedge clk_50MHz);
      k++;
    end
    check({name, "_done_count"}, (q_done.size() >= n), 1);
  endtask

  task automatic wait_bytes(input string name, input int n);
    int k = 0;
    while (q_bytes.size() < n && k < LINE) begin
      @(negedge clk_50MHz);
      k++;
    end
    check({name, "_bytes_seen"}, (q_bytes.size() >= n), 1);
  endtask

  // Pops one 14-byte line; checks content and that every frame is well formed and abuts the previous one.
  task automatic check_line(input string name, input string exp, output int t_first);
    logic [7:0] b;
    bit         ok       = 1'b1;
    bit         frame_ok = 1'b1;
    string      act      = "";
    string      exph     = "";
    int         t;
    int         prev     = 0;
    t_first = -1;
    n_tests += 2;
    if (q_bytes.size() < 14) begin
      n_fail += 2;
      $display("FAIL %s: got %0d decoded bytes, expected 14", name, q_bytes.size());
      return;
    end
    t_first = q_start[0];
    for (int i = 0; i < 14; i++) begin
      b    = q_bytes.pop_front();
      t    = q_start.pop_front();
      act  = {act, $sformatf("%02h", b)};
      exph = {exph, $sformatf("%02h", exp[i])};
      if (b != exp[i]) ok = 1'b0;
      if (!q_stop.pop_front()) frame_ok = 1'b0;
      if (i > 0 && (t - prev) != FRAME) frame_ok = 1'b0;
      prev = t;
    end
    if (!ok) begin
      n_fail++;
      $display("FAIL %s_text: got %s, expected %s", name, act, exph);
    end
    if (!frame_ok) begin
      n_fail++;
      $display("FAIL %s_framing: stop bit or frame spacing wrong (frame %0d cycles expected)", name, FRAME);
    end
  endtask

  task automatic guard_quiet(input string name, input int n_done);
    repeat (2 * FRAME) @(negedge clk_50MHz);
    check({name, "_no_extra_bytes"}, q_bytes.size(), 0);
    check({name, "_msg_done_count"}, q_done.size(), n_done);
    check({name, "_busy_low"}, busy, 1'b0);
  endtask

  initial begin : main
    vec_t        tbl[4];
    int          req_edge;
    int          t1;
    int          t2;
    int          t_prev;
    int          viol;
    logic [7:0]  rs;
    logic [7:0]  rc;
    logic [15:0] rsc;

    tbl[0] = '{8'h03, 8'h41, 16'h01A9, "S03 C41 01A9\015\012"};
    tbl[1] = '{8'hFF, 8'h00, 16'hA09F, "SFF C00 A09F\015\012"};
    tbl[2] = '{8'h0A, 8'h9F, 16'hFFFF, "S0A C9F FFFF\015\012"};
    tbl[3] = '{8'h5C, 8'hE7, 16'h0000, "S5C CE7 0000\015\012"};

    reset_n = 1'b0;
    repeat (3) @(negedge clk_50MHz);
    check("reset_uart_tx", uart_tx, 1'b1);
    check("reset_busy", busy, 1'b0);
    check("reset_msg_done", msg_done, 1'b0);
    reset_n = 1'b1;
    mon_en  = 1'b1;

    viol = 0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk_50MHz);
      if (uart_tx !== 1'b1 || busy !== 1'b0 || msg_done !== 1'b0) viol++;
    end
    check("idle_after_reset_activity", viol, 0);

    for (int i = 0; i < 4; i++) begin
      clear_q();
      request(tbl[i].s, tbl[i].c, tbl[i].sc, req_edge);
      check($sformatf("vec%0d_busy_after_req", i), busy, 1'b1);
      wait_done($sformatf("vec%0d", i), 1, LINE + 100);
      check_line($sformatf("vec%0d", i), tbl[i].exp, t1);
      check($sformatf("vec%0d_start_latency", i), t1 - req_edge, 1);
      if (q_done.size() > 0) check($sformatf("vec%0d_done_time", i), q_done[0] - t1, LINE);
      guard_quiet($sformatf("vec%0d", i), 1);
    end

    clear_q();
    request(8'h03, 8'h41, 16'h0001, req_edge);
    wait_bytes("mid1", 5);
    @(negedge clk_50MHz);
    score = 16'h0002;
    wait_done("mid1", 2, 2 * LINE + 100);
    check_line("mid1_line1", model_line(8'h03, 8'h41, 16'h0001), t1);
    check_line("mid1_line2", model_line(8'h03, 8'h41, 16'h0002), t2);
    check("mid1_back_to_back", t2 - t1, LINE);
    guard_quiet("mid1", 2);

    clear_q();
    request(8'h03, 8'h41, 16'h0003, req_edge);
    wait_bytes("mid3a", 2);
    score = 16'h0004;
    wait_bytes("mid3b", 6);
    score = 16'h0005;
    wait_bytes("mid3c", 11);
    score = 16'h0006;
    wait_done("mid3", 2, 2 * LINE + 100);
    check_line("mid3_line1", model_line(8'h03, 8'h41, 16'h0003), t1);
    check_line("mid3_line2", model_line(8'h03, 8'h41, 16'h0006), t2);
    check("mid3_back_to_back", t2 - t1, LINE);
    guard_quiet("mid3", 2);

    clear_q();
    request(8'h21, 8'h42, 16'h1234, req_edge);
    repeat (1 + 3 * CPB + CPB / 2) @(negedge clk_50MHz);
    reset_n = 1'b0;
    @(posedge clk_50MHz);
    #1;
    check("abort_uart_tx", uart_tx, 1'b1);
    check("abort_busy", busy, 1'b0);
    check("abort_msg_done", msg_done, 1'b0);
    repeat (2) @(negedge clk_50MHz);
    reset_n = 1'b1;
    repeat (2 * FRAME) @(negedge clk_50MHz);
    check("abort_no_msg_done", q_done.size(), 0);
    clear_q();
    viol = 0;
    for (int i = 0; i < 3 * FRAME; i++) begin
      @(negedge clk_50MHz);
      if (uart_tx !== 1'b1 || busy !== 1'b0) viol++;
    end
    check("abort_silent_after_release", viol, 0);
    check("abort_no_bytes", q_bytes.size(), 0);

    clear_q();
    @(negedge clk_50MHz);
    state    = 8'h07;
    ctrl     = 8'h0B;
    score    = 16'hBEEF;
    send_req = 1'b1;
    repeat (3 * LINE) @(negedge clk_50MHz);
    send_req = 1'b0;
    wait_done("hold", 4, 2 * LINE);
    t_prev = -1;
    for (int k = 0; k < 4; k++) begin
      check_line($sformatf("hold_line%0d", k), model_line(8'h07, 8'h0B, 16'hBEEF), t1);
      if (k > 0) check($sformatf("hold_spacing%0d", k), t1 - t_prev, LINE);
      t_prev = t1;
    end
    guard_quiet("hold", 4);

    for (int k = 0; k < 6; k++) begin
      rs  = 8'($urandom);
      rc  = 8'($urandom);
      rsc = 16'($urandom);
      clear_q();
      request(rs, rc, rsc, req_edge);
      wait_done($sformatf("rand%0d", k), 1, LINE + 100);
      check_line($sformatf("rand%0d", k), model_line(rs, rc, rsc), t1);
      check($sformatf("rand%0d_start_latency", k), t1 - req_edge, 1);
      if (q_done.size() > 0) check($sformatf("rand%0d_done_time", k), q_done[0] - t1, LINE);
      guard_quiet($sformatf("rand%0d", k), 1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
